if_stage: RTL and testbench

- Instruction-fetch stage directly upstream of decode. Owns the PC register and the IF/ID pipeline register.
- Consumes pc_stall, if_stall and if_flush from the CPU control block, plus jump and branch redirects.
- Drives a synchronous instruction memory with 1-cycle read latency.
- Buffers a returning instruction while stalled so no fetch is lost or duplicated.

---
 rtl/if_stage.sv | 170 +++++++++++++++++
 tb/tb_if_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage feeding decode.
// Owns the PC, issues requests to a 1-cycle-latency synchronous instruction
// memory, and keeps the IF/ID pipeline register. A single-entry hold buffer
// parks a response that returns while IF/ID is stalled, so no fetch is lost
// or duplicated.
//
// Handshake: there is no ready/valid back-pressure on the memory side.
// imem_en=1 in cycle N means imem_rdata in cycle N+1 carries the word at
// imem_addr(N). Downstream consumes IF/ID whenever if_valid=1 and
// if_stall=0. Upstream control guarantees pc_stall=1 whenever if_stall=1,
// so at most one response can be waiting in the hold buffer.
//
// Optional build macro IF_PERF_CNT_EN adds perf_stall_cyc and
// perf_redirect_cnt saturating event counters.
module if_stage #(
  parameter int              PC_W     = 32,
  parameter int              INSN_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_stall,
  input  logic              if_stall,
  input  logic              if_flush,
  input  logic              jp_taken,
  input  logic [PC_W-1:0]   jp_target,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  output logic              imem_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [PC_W-1:0]   if_pc,
  output logic [INSN_W-1:0] if_insn
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_redirect_cnt
`endif
);

  logic              r_pc_q;
  logic [PC_W-1:0]   r_pc;
  logic              r_req_valid;
  logic [PC_W-1:0]   r_req_pc;
  logic              r_hold_valid;
  logic [PC_W-1:0]   r_hold_pc;
  logic [INSN_W-1:0] r_hold_insn;
  logic              r_if_valid;
  logic [PC_W-1:0]   r_if_pc;
  logic [INSN_W-1:0] r_if_insn;

  logic              w_kill;
  logic              w_fetch;
  logic              w_hold_cap;
  logic [PC_W-1:0]   w_pc_next;

  // Redirect and fetch-enable decode; redirects override pc_stall, branch beats jump
  always_comb begin
    w_kill     = if_flush | jp_taken | br_taken;
    w_fetch    = rst_n & ~pc_stall & ~w_kill;
    w_hold_cap = r_req_valid & (if_stall | r_hold_valid) & ~w_kill;
    w_pc_next  = r_pc + PC_W'(4);
    if (br_taken) begin
      w_pc_next = br_target;
    end else if (jp_taken) begin
      w_pc_next = jp_target;
    end else if (pc_stall) begin
      w_pc_next = r_pc;
    end
  end

  assign r_pc_q    = 1'b0;
  assign imem_en   = w_fetch;
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_insn   = r_if_insn;

  // Program counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Outstanding-request tracker; a kill suppresses the request so its response is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else begin
      r_req_valid <= w_fetch;
      r_req_pc    <= r_pc;
    end
  end

  // Hold buffer: parks a response that cannot enter IF/ID this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_pc    <= '0;
      r_hold_insn  <= '0;
    end else if (w_kill) begin
      r_hold_valid <= 1'b0;
    end else if (w_hold_cap) begin
      r_hold_valid <= 1'b1;
      r_hold_pc    <= r_req_pc;
      r_hold_insn  <= imem_rdata;
    end else if (!if_stall) begin
      r_hold_valid <= 1'b0;
    end
  end

  // IF/ID register: kill, then stall, then buffered response, then live response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_insn  <= '0;
    end else if (w_kill) begin
      r_if_valid <= 1'b0;
    end else if (if_stall) begin
      r_if_valid <= r_if_valid;
    end else if (r_hold_valid) begin
      r_if_valid <= 1'b1;
      r_if_pc    <= r_hold_pc;
      r_if_insn  <= r_hold_insn;
    end else if (r_req_valid) begin
      r_if_valid <= 1'b1;
      r_if_pc    <= r_req_pc;
      r_if_insn  <= imem_rdata;
    end else begin
      r_if_valid <= 1'b0;
    end
  end

  // A second response while the hold buffer is still full would be lost
  assert property (@(posedge clk) disable iff (!rst_n)
    !(r_req_valid && r_hold_valid && !w_kill));

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_redir;

  // Saturating event counters for stall cycles and redirect cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_redir <= '0;
    end else begin
      if (if_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (w_kill && (r_perf_redir != 32'hFFFF_FFFF)) begin
        r_perf_redir <= r_perf_redir + 32'd1;
      end
    end
  end

  assign perf_stall_cyc    = r_perf_stall;
  assign perf_redirect_cnt = r_perf_redir;
`endif

  logic w_unused;
  assign w_unused = r_pc_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plus randomized bench for if_stage.
// The reference model treats the stage as a fetch stream: a queue of
// addresses awaiting memory responses and a queue of returned words waiting
// for IF/ID, with redirects emptying both.
module tb_if_stage;

  localparam logic [31:0] MAGIC = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_stall, if_stall, if_flush, jp_taken, br_taken;
  logic [31:0] jp_target, br_target;
  logic        imem_en;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_insn;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_redirect_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_inflight[$];
  logic [31:0] m_buf[$];
  logic        m_if_valid;
  logic [31:0] m_if_pc, m_if_insn;
  logic [31:0] m_stall_cnt, m_redir_cnt;

  // Clock
  always #5 clk = ~clk;

  if_stage #(.PC_W(32), .INSN_W(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_stall   (pc_stall),
    .if_stall   (if_stall),
    .if_flush   (if_flush),
    .jp_taken   (jp_taken),
    .jp_target  (jp_target),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_insn    (if_insn)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_stall_cyc    (perf_stall_cyc),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  // Synchronous instruction memory; garbage on idle cycles
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr ^ MAGIC;
    else         imem_rdata <= $urandom;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  function automatic void model_reset();
    m_pc = 32'h0;
    m_inflight.delete();
    m_buf.delete();
    m_if_valid  = 1'b0;
    m_if_pc     = 32'h0;
    m_if_insn   = 32'h0;
    m_stall_cnt = 32'h0;
    m_redir_cnt = 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check, advance model, move to next negedge
  task automatic cyc(input logic ps, input logic is, input logic fl,
                     input logic jt, input logic [31:0] jtg,
                     input logic bt, input logic [31:0] btg);
    logic        kill;
    logic [31:0] resp[$];
    pc_stall  = ps;
    if_stall  = is;
    if_flush  = fl;
    jp_taken  = jt;
    jp_target = jtg;
    br_taken  = bt;
    br_target = btg;
    kill = fl | jt | bt;
    #1;
    chk("imem_en",   {31'b0, imem_en},  {31'b0, !ps && !kill});
    chk("imem_addr", imem_addr,         m_pc);
    chk("if_valid",  {31'b0, if_valid}, {31'b0, m_if_valid});
    chk("if_pc",     if_pc,             m_if_pc);
    chk("if_insn",   if_insn,           m_if_insn);
`ifdef IF_PERF_CNT_EN
    chk("perf_stall",  perf_stall_cyc,    m_stall_cnt);
    chk("perf_redir",  perf_redirect_cnt, m_redir_cnt);
    if (is && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if (kill && m_redir_cnt != 32'hFFFF_FFFF) m_redir_cnt++;
`endif
    resp = m_inflight;
    m_inflight.delete();
    if (kill) begin
      m_buf.delete();
      m_if_valid = 1'b0;
    end else begin
      foreach (resp[k]) m_buf.push_back(resp[k]);
      if (!is) begin
        if (m_buf.size() > 0) begin
          m_if_pc    = m_buf.pop_front();
          m_if_insn  = m_if_pc ^ MAGIC;
          m_if_valid = 1'b1;
        end else begin
          m_if_valid = 1'b0;
        end
      end
    end
    if (!ps && !kill) m_inflight.push_back(m_pc);
    if (bt)       m_pc = btg;
    else if (jt)  m_pc = jtg;
    else if (!ps) m_pc = m_pc + 32'd4;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic stall();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Stimulus
  initial begin
    logic is, ps, fl, jt, bt;
    rst_n = 1'b0;
    pc_stall = 1'b0; if_stall = 1'b0; if_flush = 1'b0;
    jp_taken = 1'b0; br_taken = 1'b0;
    jp_target = 32'h0; br_target = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_if_pc",    if_pc,             32'h0);
    chk("rst_if_insn",  if_insn,           32'h0);
    chk("rst_addr",     imem_addr,         32'h0);
    rst_n = 1'b1;

    // Straight-line fetch from reset
    idle(); idle();
    chk("first_valid", {31'b0, if_valid}, 32'h1);
    chk("first_pc",    if_pc,             32'h0);
    chk("first_insn",  if_insn,           32'h0 ^ MAGIC);
    idle(); chk("seq_pc4", if_pc, 32'h4);
    idle(); chk("seq_pc8", if_pc, 32'h8);

    // Stall with request to 0x10 in flight
    idle();
    stall(); stall(); stall();
    chk("stall_hold_pc", if_pc, 32'hC);
    idle(); chk("held_pc10", if_pc, 32'h10);
    chk("held_insn10", if_insn, 32'h10 ^ MAGIC);
    idle(); chk("next_pc14", if_pc, 32'h14);

    // Jump plus flush drops the in-flight fetch
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    chk("jmp_bubble", {31'b0, if_valid}, 32'h0);
    chk("jmp_addr",   imem_addr,         32'h200);
    idle(); chk("jmp_drop", {31'b0, if_valid}, 32'h0);
    idle(); chk("jmp_valid", {31'b0, if_valid}, 32'h1);
    chk("jmp_pc", if_pc, 32'h200);

    // Branch and jump together while stalled with a held response
    stall();
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h80);
    chk("br_bubble", {31'b0, if_valid}, 32'h0);
    chk("br_addr",   imem_addr,         32'h80);
    idle(); chk("br_nohold", {31'b0, if_valid}, 32'h0);
    idle(); chk("br_pc", if_pc, 32'h80);

    // PC wrap-around
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    chk("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
    idle(); chk("wrap_addr_0", imem_addr, 32'h0);
    idle(); chk("wrap_pc_hi", if_pc, 32'hFFFF_FFFC);
    idle(); chk("wrap_pc_0", if_pc, 32'h0);

    // Randomized control traffic; if_stall always implies pc_stall
    for (int i = 0; i < 500; i++) begin
      is = ($urandom_range(0, 3) == 0);
      ps = is | ($urandom_range(0, 6) == 0);
      fl = ($urandom_range(0, 19) == 0);
      jt = ($urandom_range(0, 14) == 0);
      bt = ($urandom_range(0, 19) == 0);
      cyc(ps, is, fl, jt, $urandom & 32'hFFFF_FFFC, bt, $urandom & 32'hFFFF_FFFC);
    end

    // Asynchronous reset while stalled with a held response
    idle(); idle();
    stall();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("arst_if_pc",    if_pc,             32'h0);
    chk("arst_if_insn",  if_insn,           32'h0);
    chk("arst_en",       {31'b0, imem_en},  32'h0);
    chk("arst_addr",     imem_addr,         32'h0);
`ifdef IF_PERF_CNT_EN
    chk("arst_perf_stall", perf_stall_cyc,    32'h0);
    chk("arst_perf_redir", perf_redirect_cnt, 32'h0);
`endif
    pc_stall = 1'b0; if_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(); idle();
    chk("restart_pc0", if_pc, 32'h0);
    chk("restart_valid", {31'b0, if_valid}, 32'h1);
    idle(); chk("restart_pc4", if_pc, 32'h4);
    idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
